// File: rtl/cu_intr_seq.sv
// RAT CPU instruction sequencer (INIT/FETCH/EXEC/INTR) with a prioritised,
// maskable multi-channel interrupt front end and its control strobes.
module cu_intr_seq #(
    parameter int          NUM_IRQ   = 4,
    parameter int          PC_W      = 10,
    parameter int unsigned VEC_BASE  = 32'h0000_03FF,
    parameter int          EDGE_MODE = 1,
    localparam int         IW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               irq_en_we,
    input  logic [NUM_IRQ-1:0] irq_en_wdata,
    input  logic               exec_sei,
    input  logic               exec_cli,
    input  logic               exec_retid,
    input  logic               exec_retie,
    output logic               rst_out,
    output logic               exec_en,
    output logic               pc_inc,
    output logic               pc_ld,
    output logic [1:0]         pc_mux_sel,
    output logic               sp_incr,
    output logic               sp_decr,
    output logic               scr_we,
    output logic               scr_data_sel,
    output logic [1:0]         scr_addr_sel,
    output logic               flg_shad_ld,
    output logic               flg_ld_sel,
    output logic               flg_c_ld,
    output logic               flg_z_ld,
    output logic               ie,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [IW-1:0]      irq_id,
    output logic [PC_W-1:0]    irq_vector
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_INTR  = 2'd3
    } state_t;

    state_t              state_q;
    logic                rst_out_q;
    logic                pc_inc_q;
    logic                exec_en_q;
    logic                intr_q;
    logic                ie_q;
    logic [NUM_IRQ-1:0]  irq_en_q;
    logic [NUM_IRQ-1:0]  ack_q;
    logic [NUM_IRQ-1:0]  ack_d;
    logic [IW-1:0]       irq_id_q;
    logic [PC_W-1:0]     irq_vector_q;
    logic [NUM_IRQ-1:0]  pend_s;
    logic [NUM_IRQ-1:0]  req_s;
    logic [IW-1:0]       sel_s;
    logic [PC_W-1:0]     base_s;
    logic [PC_W-1:0]     vec_s;
    logic                ie_next_s;
    logic                take_s;
    logic                ret_s;

    // Channel enable register, writable in every state
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en_q <= '0;
        end else if (irq_en_we) begin
            irq_en_q <= irq_en_wdata;
        end else begin
            irq_en_q <= irq_en_q;
        end
    end

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [NUM_IRQ-1:0] irq_in_q;
            logic [NUM_IRQ-1:0] pend_q;

            // Rising-edge capture; a new edge wins over the service clear
            always_ff @(posedge clk) begin
                if (!reset) begin
                    irq_in_q <= '0;
                    pend_q   <= '0;
                end else begin
                    irq_in_q <= irq_in;
                    pend_q   <= (pend_q & ~(intr_q ? ack_q : {NUM_IRQ{1'b0}}))
                              | (irq_in & ~irq_in_q);
                end
            end
            assign pend_s = pend_q;
        end else begin : g_level
            assign pend_s = irq_in;
        end
    endgenerate

    // Global enable after this EXEC, then lowest enabled pending channel
    always_comb begin
        ie_next_s = ie_q;
        if (exec_sei || exec_retie) begin
            ie_next_s = 1'b1;
        end else if (exec_cli || exec_retid) begin
            ie_next_s = 1'b0;
        end else begin
            ie_next_s = ie_q;
        end
        req_s = pend_s & irq_en_q;
        sel_s = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_s[i]) begin
                sel_s = IW'(i);
            end else begin
                sel_s = sel_s;
            end
        end
        ack_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_d[i] = (sel_s == IW'(i));
        end
        base_s = PC_W'(VEC_BASE);
        vec_s  = base_s - PC_W'(sel_s);
        take_s = (state_q == S_EXEC) && ie_next_s && (|req_s);
    end

    // Sequencer FSM with state-decoded strobes registered alongside the state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_INIT;
            rst_out_q    <= 1'b1;
            pc_inc_q     <= 1'b0;
            exec_en_q    <= 1'b0;
            intr_q       <= 1'b0;
            ie_q         <= 1'b0;
            ack_q        <= '0;
            irq_id_q     <= '0;
            irq_vector_q <= '0;
        end else begin
            rst_out_q <= 1'b0;
            pc_inc_q  <= 1'b0;
            exec_en_q <= 1'b0;
            intr_q    <= 1'b0;
            ack_q     <= '0;
            case (state_q)
                S_INIT: begin
                    state_q  <= S_FETCH;
                    pc_inc_q <= 1'b1;
                end
                S_FETCH: begin
                    state_q   <= S_EXEC;
                    exec_en_q <= 1'b1;
                end
                S_EXEC: begin
                    if (take_s) begin
                        state_q      <= S_INTR;
                        intr_q       <= 1'b1;
                        ie_q         <= 1'b0;
                        ack_q        <= ack_d;
                        irq_id_q     <= sel_s;
                        irq_vector_q <= vec_s;
                    end else begin
                        state_q  <= S_FETCH;
                        pc_inc_q <= 1'b1;
                        ie_q     <= ie_next_s;
                    end
                end
                S_INTR: begin
                    state_q  <= S_FETCH;
                    pc_inc_q <= 1'b1;
                    ie_q     <= 1'b0;
                end
                default: begin
                    state_q   <= S_INIT;
                    rst_out_q <= 1'b1;
                    ie_q      <= 1'b0;
                end
            endcase
        end
    end

    // Return strobes follow the decoder flags within the EXEC cycle
    assign ret_s        = exec_en_q & (exec_retid | exec_retie);

    assign rst_out      = rst_out_q;
    assign exec_en      = exec_en_q;
    assign pc_inc       = pc_inc_q;
    assign pc_ld        = intr_q | ret_s;
    assign pc_mux_sel   = intr_q ? 2'd2 : (ret_s ? 2'd1 : 2'd0);
    assign sp_incr      = ret_s;
    assign sp_decr      = intr_q;
    assign scr_we       = intr_q;
    assign scr_data_sel = intr_q;
    assign scr_addr_sel = intr_q ? 2'd3 : (ret_s ? 2'd2 : 2'd0);
    assign flg_shad_ld  = intr_q;
    assign flg_ld_sel   = ret_s;
    assign flg_c_ld     = ret_s;
    assign flg_z_ld     = ret_s;
    assign ie           = ie_q;
    assign irq_pending  = pend_s;
    assign irq_ack      = ack_q;
    assign irq_id       = irq_id_q;
    assign irq_vector   = irq_vector_q;

endmodule

// File: tb/tb_cu_intr_seq.sv
// Directed bench for cu_intr_seq: edge-mode instance for the sequencing and
// priority scenarios, level-mode instance for held-line re-entry and masking.
module tb_cu_intr_seq;
    localparam int N  = 4;
    localparam int PW = 10;
    localparam logic [12:0] STRB_INTR = 13'b1100111111000;
    localparam logic [12:0] STRB_RET  = 13'b1011000100111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic          reset;
    logic [N-1:0]  irq_in, l_irq_in;
    logic          irq_en_we, l_en_we;
    logic [N-1:0]  irq_en_wdata, l_en_wdata;
    logic          exec_sei, exec_cli, exec_retid, exec_retie;

    logic rst_out, exec_en, pc_inc, pc_ld, sp_incr, sp_decr, scr_we, scr_data_sel;
    logic flg_shad_ld, flg_ld_sel, flg_c_ld, flg_z_ld, ie;
    logic [1:0] pc_mux_sel, scr_addr_sel, irq_id;
    logic [N-1:0] irq_pending, irq_ack;
    logic [PW-1:0] irq_vector;

    logic l_rst_out, l_exec_en, l_pc_inc, l_pc_ld, l_sp_incr, l_sp_decr, l_scr_we, l_scr_data_sel;
    logic l_flg_shad_ld, l_flg_ld_sel, l_flg_c_ld, l_flg_z_ld, l_ie;
    logic [1:0] l_pc_mux_sel, l_scr_addr_sel, l_irq_id;
    logic [N-1:0] l_irq_pending, l_irq_ack;
    logic [PW-1:0] l_irq_vector;

    logic [12:0] strb;
    assign strb = {pc_ld, pc_mux_sel, sp_incr, sp_decr, scr_we, scr_data_sel,
                   scr_addr_sel, flg_shad_ld, flg_ld_sel, flg_c_ld, flg_z_ld};

    cu_intr_seq #(.NUM_IRQ(N), .PC_W(PW), .VEC_BASE(32'h0000_03FF), .EDGE_MODE(1)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .irq_en_we(irq_en_we),
        .irq_en_wdata(irq_en_wdata), .exec_sei(exec_sei), .exec_cli(exec_cli),
        .exec_retid(exec_retid), .exec_retie(exec_retie), .rst_out(rst_out),
        .exec_en(exec_en), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_mux_sel(pc_mux_sel),
        .sp_incr(sp_incr), .sp_decr(sp_decr), .scr_we(scr_we), .scr_data_sel(scr_data_sel),
        .scr_addr_sel(scr_addr_sel), .flg_shad_ld(flg_shad_ld), .flg_ld_sel(flg_ld_sel),
        .flg_c_ld(flg_c_ld), .flg_z_ld(flg_z_ld), .ie(ie), .irq_pending(irq_pending),
        .irq_ack(irq_ack), .irq_id(irq_id), .irq_vector(irq_vector));

    cu_intr_seq #(.NUM_IRQ(N), .PC_W(PW), .VEC_BASE(32'h0000_03FF), .EDGE_MODE(0)) dut_l (
        .clk(clk), .reset(reset), .irq_in(l_irq_in), .irq_en_we(l_en_we),
        .irq_en_wdata(l_en_wdata), .exec_sei(exec_sei), .exec_cli(exec_cli),
        .exec_retid(exec_retid), .exec_retie(exec_retie), .rst_out(l_rst_out),
        .exec_en(l_exec_en), .pc_inc(l_pc_inc), .pc_ld(l_pc_ld), .pc_mux_sel(l_pc_mux_sel),
        .sp_incr(l_sp_incr), .sp_decr(l_sp_decr), .scr_we(l_scr_we), .scr_data_sel(l_scr_data_sel),
        .scr_addr_sel(l_scr_addr_sel), .flg_shad_ld(l_flg_shad_ld), .flg_ld_sel(l_flg_ld_sel),
        .flg_c_ld(l_flg_c_ld), .flg_z_ld(l_flg_z_ld), .ie(l_ie), .irq_pending(l_irq_pending),
        .irq_ack(l_irq_ack), .irq_id(l_irq_id), .irq_vector(l_irq_vector));

    task automatic test_reset();
        logic [3:0] exp;
        reset = 1'b0; irq_in = '0; l_irq_in = '0; irq_en_we = 1'b0; l_en_we = 1'b0;
        irq_en_wdata = '0; l_en_wdata = '0;
        exec_sei = 1'b0; exec_cli = 1'b0; exec_retid = 1'b0; exec_retie = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rst_out, pc_inc, exec_en, ie} !== 4'b1000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=1000", {rst_out, pc_inc, exec_en, ie});
        end
        checks++;
        if ({strb, irq_ack, irq_pending, irq_id, irq_vector} !== 33'd0) begin
            failures++; $display("FAIL reset_zero got=%h exp=0", {strb, irq_ack, irq_pending, irq_id, irq_vector});
        end
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = (k % 2 == 0) ? 4'b0100 : 4'b0010;
            checks++;
            if ({rst_out, pc_inc, exec_en, ie} !== exp) begin
                failures++; $display("FAIL reset_seq%0d got=%b exp=%b", k, {rst_out, pc_inc, exec_en, ie}, exp);
            end
            checks++;
            if ({strb, irq_ack} !== 17'd0) begin
                failures++; $display("FAIL reset_strb%0d got=%h exp=0", k, {strb, irq_ack});
            end
        end
    endtask

    task automatic test_single_irq();
        irq_en_we = 1'b1; irq_en_wdata = 4'b1111; exec_sei = 1'b1;
        @(negedge clk);
        irq_en_we = 1'b0; exec_sei = 1'b0;
        checks++;
        if ({pc_inc, exec_en, ie} !== 3'b101) begin
            failures++; $display("FAIL sei_ie got=%b exp=101", {pc_inc, exec_en, ie});
        end
        irq_in = 4'b0100;
        @(negedge clk);
        irq_in = 4'b0000;
        checks++;
        if ({exec_en, irq_pending} !== 5'b1_0100) begin
            failures++; $display("FAIL single_pend got=%b exp=10100", {exec_en, irq_pending});
        end
        @(negedge clk);
        checks++;
        if (strb !== STRB_INTR) begin
            failures++; $display("FAIL single_intr_strb got=%b exp=%b", strb, STRB_INTR);
        end
        checks++;
        if ({irq_ack, irq_id, irq_vector, exec_en, pc_inc, ie} !== {4'b0100, 2'd2, 10'h3FD, 3'b000}) begin
            failures++; $display("FAIL single_intr got=%h exp=%h", {irq_ack, irq_id, irq_vector, exec_en, pc_inc, ie},
                                 {4'b0100, 2'd2, 10'h3FD, 3'b000});
        end
        @(negedge clk);
        checks++;
        if ({pc_inc, ie, irq_pending, irq_ack, irq_vector} !== {1'b1, 1'b0, 4'b0000, 4'b0000, 10'h3FD}) begin
            failures++; $display("FAIL single_after got=%h exp=%h", {pc_inc, ie, irq_pending, irq_ack, irq_vector},
                                 {1'b1, 1'b0, 4'b0000, 4'b0000, 10'h3FD});
        end
    endtask

    task automatic test_priority();
        irq_in = 4'b1010;
        @(negedge clk);
        irq_in = 4'b0000; exec_retie = 1'b1;
        #1;
        checks++;
        if ({exec_en, irq_pending, strb} !== {1'b1, 4'b1010, STRB_RET}) begin
            failures++; $display("FAIL prio_ret got=%b exp=%b", {exec_en, irq_pending, strb}, {1'b1, 4'b1010, STRB_RET});
        end
        @(negedge clk);
        exec_retie = 1'b0;
        checks++;
        if ({irq_ack, irq_id, irq_vector} !== {4'b0010, 2'd1, 10'h3FE}) begin
            failures++; $display("FAIL prio_first got=%h exp=%h", {irq_ack, irq_id, irq_vector}, {4'b0010, 2'd1, 10'h3FE});
        end
        @(negedge clk);
        checks++;
        if ({irq_pending, ie, pc_inc} !== 6'b1000_0_1) begin
            failures++; $display("FAIL prio_left got=%b exp=100001", {irq_pending, ie, pc_inc});
        end
        @(negedge clk);
        exec_retie = 1'b1;
        @(negedge clk);
        exec_retie = 1'b0;
        checks++;
        if ({irq_ack, irq_id, irq_vector, strb} !== {4'b1000, 2'd3, 10'h3FC, STRB_INTR}) begin
            failures++; $display("FAIL prio_second got=%h exp=%h", {irq_ack, irq_id, irq_vector, strb},
                                 {4'b1000, 2'd3, 10'h3FC, STRB_INTR});
        end
        @(negedge clk);
        checks++;
        if (irq_pending !== 4'b0000) begin
            failures++; $display("FAIL prio_clear got=%b exp=0000", irq_pending);
        end
    endtask

    task automatic test_cli_sei();
        @(negedge clk);
        exec_sei = 1'b1;
        @(negedge clk);
        exec_sei = 1'b0;
        checks++;
        if ({ie, pc_inc} !== 2'b11) begin
            failures++; $display("FAIL cli_pre got=%b exp=11", {ie, pc_inc});
        end
        irq_in = 4'b0001;
        @(negedge clk);
        irq_in = 4'b0000; exec_cli = 1'b1;
        #1;
        checks++;
        if ({strb, irq_pending} !== {13'd0, 4'b0001}) begin
            failures++; $display("FAIL cli_strb got=%b exp=%b", {strb, irq_pending}, {13'd0, 4'b0001});
        end
        @(negedge clk);
        exec_cli = 1'b0;
        checks++;
        if ({pc_inc, exec_en, ie, strb, irq_ack, irq_pending} !== {3'b100, 13'd0, 4'b0000, 4'b0001}) begin
            failures++; $display("FAIL cli_no_intr got=%b exp=%b", {pc_inc, exec_en, ie, strb, irq_ack, irq_pending},
                                 {3'b100, 13'd0, 4'b0000, 4'b0001});
        end
        @(negedge clk);
        exec_sei = 1'b1;
        #1;
        checks++;
        if (strb !== 13'd0) begin
            failures++; $display("FAIL sei_strb got=%b exp=0", strb);
        end
        @(negedge clk);
        exec_sei = 1'b0;
        checks++;
        if ({irq_ack, irq_id, irq_vector} !== {4'b0001, 2'd0, 10'h3FF}) begin
            failures++; $display("FAIL sei_intr got=%h exp=%h", {irq_ack, irq_id, irq_vector}, {4'b0001, 2'd0, 10'h3FF});
        end
        @(negedge clk);
        checks++;
        if ({irq_pending, ie} !== 5'b0000_0) begin
            failures++; $display("FAIL sei_after got=%b exp=00000", {irq_pending, ie});
        end
    endtask

    task automatic test_en_boundary();
        irq_in = 4'b0010;
        @(negedge clk);
        irq_in = 4'b0000; exec_sei = 1'b1; irq_en_we = 1'b1; irq_en_wdata = 4'b0000;
        @(negedge clk);
        exec_sei = 1'b0; irq_en_we = 1'b0;
        checks++;
        if ({irq_ack, irq_id} !== {4'b0010, 2'd1}) begin
            failures++; $display("FAIL en_old got=%b exp=%b", {irq_ack, irq_id}, {4'b0010, 2'd1});
        end
        @(negedge clk);
        irq_in = 4'b0001;
        @(negedge clk);
        irq_in = 4'b0000; exec_sei = 1'b1;
        @(negedge clk);
        exec_sei = 1'b0;
        checks++;
        if ({pc_inc, exec_en, ie, irq_ack, irq_pending} !== {3'b101, 4'b0000, 4'b0001}) begin
            failures++; $display("FAIL en_masked got=%b exp=%b", {pc_inc, exec_en, ie, irq_ack, irq_pending},
                                 {3'b101, 4'b0000, 4'b0001});
        end
        irq_en_we = 1'b1; irq_en_wdata = 4'b0001;
        @(negedge clk);
        irq_en_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({irq_ack, irq_vector, pc_mux_sel} !== {4'b0001, 10'h3FF, 2'd2}) begin
            failures++; $display("FAIL en_unmask got=%h exp=%h", {irq_ack, irq_vector, pc_mux_sel}, {4'b0001, 10'h3FF, 2'd2});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_intr();
        irq_in = 4'b0011;
        @(negedge clk);
        irq_in = 4'b0000; exec_sei = 1'b1;
        @(negedge clk);
        exec_sei = 1'b0;
        checks++;
        if ({irq_ack, irq_pending} !== {4'b0001, 4'b0011}) begin
            failures++; $display("FAIL rintr_pre got=%b exp=%b", {irq_ack, irq_pending}, {4'b0001, 4'b0011});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({rst_out, pc_inc, exec_en, ie} !== 4'b1000) begin
            failures++; $display("FAIL rintr_init got=%b exp=1000", {rst_out, pc_inc, exec_en, ie});
        end
        checks++;
        if ({strb, irq_ack, irq_pending, irq_id, irq_vector} !== 33'd0) begin
            failures++; $display("FAIL rintr_zero got=%h exp=0", {strb, irq_ack, irq_pending, irq_id, irq_vector});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rst_out, pc_inc} !== 2'b01) begin
            failures++; $display("FAIL rintr_fetch got=%b exp=01", {rst_out, pc_inc});
        end
    endtask

    task automatic test_level_mode();
        l_en_we = 1'b1; l_en_wdata = 4'b0001; l_irq_in = 4'b0011;
        @(negedge clk);
        l_en_we = 1'b0; exec_sei = 1'b1;
        checks++;
        if ({l_exec_en, l_irq_pending} !== 5'b1_0011) begin
            failures++; $display("FAIL lvl_pend got=%b exp=10011", {l_exec_en, l_irq_pending});
        end
        @(negedge clk);
        exec_sei = 1'b0;
        checks++;
        if ({l_irq_ack, l_irq_vector, l_ie} !== {4'b0001, 10'h3FF, 1'b0}) begin
            failures++; $display("FAIL lvl_first got=%h exp=%h", {l_irq_ack, l_irq_vector, l_ie}, {4'b0001, 10'h3FF, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({l_irq_pending, l_irq_ack} !== {4'b0011, 4'b0000}) begin
            failures++; $display("FAIL lvl_held got=%b exp=00110000", {l_irq_pending, l_irq_ack});
        end
        @(negedge clk);
        exec_retie = 1'b1;
        @(negedge clk);
        exec_retie = 1'b0;
        checks++;
        if ({l_irq_ack, l_pc_mux_sel} !== {4'b0001, 2'd2}) begin
            failures++; $display("FAIL lvl_reentry got=%b exp=000110", {l_irq_ack, l_pc_mux_sel});
        end
        @(negedge clk);
        l_irq_in = 4'b0010;
        @(negedge clk);
        exec_retie = 1'b1;
        @(negedge clk);
        exec_retie = 1'b0;
        checks++;
        if ({l_pc_inc, l_irq_ack, l_ie, l_irq_pending} !== {1'b1, 4'b0000, 1'b1, 4'b0010}) begin
            failures++; $display("FAIL lvl_drop got=%b exp=%b", {l_pc_inc, l_irq_ack, l_ie, l_irq_pending},
                                 {1'b1, 4'b0000, 1'b1, 4'b0010});
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({l_irq_ack, l_pc_ld} !== 5'b0) begin
                failures++; $display("FAIL lvl_masked%0d got=%b exp=00000", k, {l_irq_ack, l_pc_ld});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_irq();
        test_priority();
        test_cli_sei();
        test_en_boundary();
        test_reset_in_intr();
        test_level_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
